shift_cmd_queue_16bit: RTL and testbench



---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift_cmd_queue_16bit_shifter.sv | 21 ++
 rtl/shift_cmd_queue_16bit.sv | 120 ++++++++++++
 tb/tb_shift_cmd_queue_16bit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the 16-bit shifter command queue.
// SHIFT_ROTATE_EN adds a per-command rotate bit to shift_cmd_t.
package shift_pkg;

  localparam int SHIFT_W     = 16;
  localparam int SHIFT_AMT_W = 4;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef struct packed {
    logic [SHIFT_W-1:0]     a;
    logic [SHIFT_AMT_W-1:0] amt;
    logic                   choice;
`ifdef SHIFT_ROTATE_EN
    logic                   rot;
`endif
  } shift_cmd_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/shift_cmd_queue_16bit_shifter.sv
// Combinational 16-bit zero-fill shifter: left or logical right by 0..15.
module Shift_left_or_right_case_16bit
  import shift_pkg::*;
(
  input  logic [SHIFT_W-1:0]     a,
  input  logic [SHIFT_AMT_W-1:0] amt,
  input  logic                   choice,
  output logic [SHIFT_W-1:0]     y
);

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    y = a;
    case (choice)
      DIR_LEFT:  y = a << amt;
      DIR_RIGHT: y = a >> amt;
      default:   y = a;
    endcase
  end

endmodule

// File: rtl/shift_cmd_queue_16bit.sv
// Valid/ready command queue in front of the 16-bit shifter with a registered result.
// Optional SHIFT_ROTATE_EN adds in_rot, turning a command into a rotate.
module shift_cmd_queue_16bit
  import shift_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = SHIFT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_a,
  input  logic [SHIFT_AMT_W-1:0]   in_amt,
  input  logic                     in_choice,
`ifdef SHIFT_ROTATE_EN
  input  logic                     in_rot,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_y,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  shift_cmd_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  shift_cmd_t wr_cmd, head;
  logic push, load;
  logic [W-1:0] shift_y, result;
  out_state_t state_q, state_d;

  always_comb begin
    wr_cmd        = '0;
    wr_cmd.a      = in_a;
    wr_cmd.amt    = in_amt;
    wr_cmd.choice = in_choice;
`ifdef SHIFT_ROTATE_EN
    wr_cmd.rot    = in_rot;
`endif
  end

  // in_ready comes from registered level only, so out_ready never reaches it.
  assign in_ready = (level != LVL_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign load     = (level != '0) && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];

  Shift_left_or_right_case_16bit u_shifter (
    .a      (head.a),
    .amt    (head.amt),
    .choice (head.choice),
    .y      (shift_y)
  );

`ifdef SHIFT_ROTATE_EN
  logic [W-1:0] rot_y;
  logic [4:0]   inv_amt;

  assign inv_amt = 5'(SHIFT_W) - {1'b0, head.amt};

  always_comb begin
    rot_y = head.a;
    if (head.choice == DIR_LEFT)
      rot_y = (head.a << head.amt) | (head.a >> inv_amt);
    else
      rot_y = (head.a >> head.amt) | (head.a << inv_amt);
  end

  assign result = head.rot ? rot_y : shift_y;
`else
  assign result = shift_y;
`endif

  // NOTE: FIFO storage has no reset; valid entries are tracked by the pointers,
  // so clearing the array would only cost flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_cmd;
  end

  // NOTE: all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, load})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OUT_EMPTY;
      out_y   <= '0;
    end else begin
      state_q <= state_d;
      if (load) out_y <= result;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_valid = (state_q == OUT_FULL);
    case (state_q)
      OUT_EMPTY: if (load) state_d = OUT_FULL;
      OUT_FULL:  if (out_ready && !load) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

endmodule

// File: tb/tb_shift_cmd_queue_16bit.sv
// Directed self-checking bench for shift_cmd_queue_16bit (rotate cases under SHIFT_ROTATE_EN).
module tb_shift_cmd_queue_16bit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [3:0]  in_amt;
  logic        in_choice;
`ifdef SHIFT_ROTATE_EN
  logic        in_rot;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic [2:0]  level;

  int n_checks = 0;
  int n_errors = 0;

  shift_cmd_queue_16bit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .in_choice (in_choice),
`ifdef SHIFT_ROTATE_EN
    .in_rot    (in_rot),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .level     (level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [3:0] amt,
                       input logic ch, input logic rot);
    in_valid  = v;
    in_a      = a;
    in_amt    = amt;
    in_choice = ch;
`ifdef SHIFT_ROTATE_EN
    in_rot    = rot;
`else
    if (rot) $display("note: rotate request ignored in this build");
`endif
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 16'h0000);
    check("rst_level", level, 0);
    tick();
    reset = 1'b0;

    // Single command: F3FF << 4, two-edge latency
    out_ready = 1'b1;
    drive(1'b1, 16'hF3FF, 4'd4, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    check("t1_valid_after_accept", out_valid, 0);
    check("t1_level_after_accept", level, 1);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_y", out_y, 16'h3FF0);
    check("t1_level", level, 0);
    tick();
    check("t1_drained", out_valid, 0);

    // Max amounts, back-to-back at full throughput
    drive(1'b1, 16'h0001, 4'd15, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'hFFFF, 4'd15, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    check("max_left_y", out_y, 16'h8000);
    tick();
    check("max_right_valid", out_valid, 1);
    check("max_right_y", out_y, 16'h0001);
    tick();
    check("max_drained", out_valid, 0);
    check("max_level", level, 0);

    // Burst of 5 with consumer stalled: 1 in output, 4 queued
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 4'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0001, 4'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0001, 4'd3, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h0001, 4'd4, 1'b1, 1'b0); tick();
    check("burst_ready_before_last", in_ready, 1);
    drive(1'b1, 16'h0001, 4'd8, 1'b1, 1'b0); tick();
    check("burst_level_full", level, 4);
    check("burst_in_ready_low", in_ready, 0);
    check("burst_out_valid", out_valid, 1);
    check("burst_head_y", out_y, 16'h0000);
    // Extra command while full must be ignored, including on the pop edge
    drive(1'b1, 16'hFFFF, 4'd0, 1'b1, 1'b0);
    tick();
    check("burst_refused_level", level, 4);
    out_ready = 1'b1;
    tick();
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    check("drain1_y", out_y, 16'h0000);
    check("drain1_level", level, 3);
    tick();
    check("drain2_y", out_y, 16'h0000);
    check("drain2_level", level, 2);
    tick();
    check("drain3_y", out_y, 16'h0010);
    check("drain3_level", level, 1);
    tick();
    check("drain4_y", out_y, 16'h0100);
    check("drain4_level", level, 0);
    tick();
    check("drain_refused_absent", out_valid, 0);

    // Fill to level 2 behind a stalled result, then stream 8 cycles
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h0001, 4'(k), 1'b1, 1'b0);
      tick();
    end
    check("stream_pre_level", level, 2);
    check("stream_pre_y_amt0", out_y, 16'h0001);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h0001, 4'(i + 3), 1'b1, 1'b0);
      tick();
      check($sformatf("stream_level_%0d", i), level, 2);
      check($sformatf("stream_y_%0d", i), out_y, 16'h0001 << (i + 1));
    end

    // Stall 3 cycles with a valid result
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_y_%0d", i), out_y, 16'h0100);
      check($sformatf("stall_level_%0d", i), level, 2);
      check($sformatf("stall_valid_%0d", i), out_valid, 1);
    end

    // Reach level 3, then assert reset asynchronously mid-cycle
    drive(1'b1, 16'h0001, 4'd11, 1'b1, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    check("pre_reset_level", level, 3);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_level", level, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_y", out_y, 16'h0000);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_valid_%0d", i), out_valid, 0);
      check($sformatf("post_rst_level_%0d", i), level, 0);
    end

`ifdef SHIFT_ROTATE_EN
    drive(1'b1, 16'h8001, 4'd1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 16'h8001, 4'd1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    check("rot_left_y", out_y, 16'h0003);
    tick();
    check("rot_right_y", out_y, 16'hC000);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
